// File: rtl/rob_retire.sv
// rob_retire: 64-entry reorder buffer. Up to four in-order allocations per
// cycle, completion from four forwarding buses, and in-order retire of up to
// two entries per cycle to the register file's two write ports.
// Latency: retire outputs are combinational from registered state. A completion
// at edge N can retire at edge N+1. Lookups are combinational and do not see
// same-cycle forwards.
// Backpressure: alloc_ready drops when fewer than four entries are free. An
// allocation while it is low, or with alloc_count > 4, is dropped whole.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   alloc_count/wreg/dest/pc   allocation request, slot 0 in the low bits
//   alloc_ready, alloc_tag     allocation handshake and the tags being handed out
//   forwardA..forwardD         {valid, tag, value} result buses
//   flush                      discard every entry at the edge
//   lookup_tag0/1 -> lookup_ready0/1, lookup_value0/1   operand lookup
//   wen/waddr/wdata 0/1        retire write ports (0 is older)
//   retire_count, retire_pc0/1 retire bookkeeping
//   rob_count                  occupied entries
module rob_retire #(
  parameter int DEPTH = 64,
  localparam int TW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        alloc_count,
  input  logic [3:0]        alloc_wreg,
  input  logic [11:0]       alloc_dest,
  input  logic [63:0]       alloc_pc,
  output logic              alloc_ready,
  output logic [4*TW-1:0]   alloc_tag,
  input  logic [TW+16:0]    forwardA,
  input  logic [TW+16:0]    forwardB,
  input  logic [TW+16:0]    forwardC,
  input  logic [TW+16:0]    forwardD,
  input  logic              flush,
  input  logic [TW-1:0]     lookup_tag0,
  input  logic [TW-1:0]     lookup_tag1,
  output logic              lookup_ready0,
  output logic              lookup_ready1,
  output logic [15:0]       lookup_value0,
  output logic [15:0]       lookup_value1,
  output logic              wen0,
  output logic [2:0]        waddr0,
  output logic [15:0]       wdata0,
  output logic              wen1,
  output logic [2:0]        waddr1,
  output logic [15:0]       wdata1,
  output logic [1:0]        retire_count,
  output logic [15:0]       retire_pc0,
  output logic [15:0]       retire_pc1,
  output logic [TW:0]       rob_count
);

  localparam int CW = TW + 1;
  typedef logic [TW-1:0] tag_t;

  // Control state
  tag_t             head;
  tag_t             tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] readyBits;

  // Entry payload; validity is tracked by head/count, so no reset is needed
  logic [15:0]      valueMem [DEPTH];
  logic             wregMem  [DEPTH];
  logic [2:0]       destMem  [DEPTH];
  logic [15:0]      pcMem    [DEPTH];

  logic [TW+16:0]   fwdBus [4];
  logic             fwdHit [4];
  logic             allocGo;
  logic [CW-1:0]    allocNum;
  logic [CW-1:0]    retireNum;
  tag_t             headNext;
  logic             retire0;
  logic             retire1;
  logic             sameDest;

  // A tag is occupied when its distance from head is below the occupancy.
  function automatic logic isOccupied(input tag_t t, input tag_t h,
                                      input logic [CW-1:0] c);
    tag_t off;
    off = t - h;
    return ({1'b0, off} < c);
  endfunction

  // Completion: buses are indexed A..D so that the later write in the
  // sequential loops below gives D priority on a shared tag.
  always_comb begin
    fwdBus[0] = forwardA;
    fwdBus[1] = forwardB;
    fwdBus[2] = forwardC;
    fwdBus[3] = forwardD;
    for (int k = 0; k < 4; k++) begin
      fwdHit[k] = fwdBus[k][TW+16] && isOccupied(fwdBus[k][TW+15:16], head, count);
    end
  end

  // Allocation
  assign alloc_ready = (count <= CW'(DEPTH - 4));
  assign allocGo     = !flush && alloc_ready && (alloc_count != 3'd0) &&
                       (alloc_count <= 3'd4);
  assign allocNum    = allocGo ? CW'(alloc_count) : '0;

  always_comb begin
    alloc_tag = '0;
    for (int i = 0; i < 4; i++) begin
      alloc_tag[i*TW +: TW] = tail + tag_t'(i);
    end
  end

  // Retire: head first, head+1 only behind it. The count gate keeps stale
  // ready bits from retiring out of an empty buffer.
  assign headNext = head + tag_t'(1);
  assign retire0  = (count != '0) && readyBits[head];
  assign retire1  = retire0 && (count >= CW'(2)) && readyBits[headNext];

  // Two writes to one register in a cycle: let the younger one through only.
  assign sameDest = retire1 && wregMem[head] && wregMem[headNext] &&
                    (destMem[head] == destMem[headNext]);

  assign retire_count = {retire1, retire0 & ~retire1};
  assign retireNum    = CW'(retire_count);

  assign wen0       = retire0 && wregMem[head] && !sameDest;
  assign waddr0     = destMem[head];
  assign wdata0     = valueMem[head];
  assign retire_pc0 = pcMem[head];

  assign wen1       = retire1 && wregMem[headNext];
  assign waddr1     = destMem[headNext];
  assign wdata1     = valueMem[headNext];
  assign retire_pc1 = pcMem[headNext];

  assign rob_count  = count;

  // Lookup reads the stored state only; a same-cycle forward is not bypassed.
  assign lookup_ready0 = readyBits[lookup_tag0];
  assign lookup_ready1 = readyBits[lookup_tag1];
  assign lookup_value0 = valueMem[lookup_tag0];
  assign lookup_value1 = valueMem[lookup_tag1];

  // Pointers, occupancy and ready bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      readyBits <= '0;
    end else if (flush) begin
      // Retire writes of this cycle still happen downstream; state restarts.
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      readyBits <= '0;
    end else begin
      head  <= head + tag_t'(retireNum);
      tail  <= tail + tag_t'(allocNum);
      count <= count + allocNum - retireNum;
      for (int k = 0; k < 4; k++) begin
        if (fwdHit[k]) begin
          readyBits[fwdBus[k][TW+15:16]] <= 1'b1;
        end
      end
      // Allocation targets are free entries, so they never collide with a hit.
      for (int i = 0; i < 4; i++) begin
        if (allocGo && (3'(i) < alloc_count)) begin
          readyBits[tail + tag_t'(i)] <= 1'b0;
        end
      end
    end
  end

  // Entry payload
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int k = 0; k < 4; k++) begin
        if (fwdHit[k]) begin
          valueMem[fwdBus[k][TW+15:16]] <= fwdBus[k][15:0];
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (allocGo && (3'(i) < alloc_count)) begin
          wregMem[tail + tag_t'(i)] <= alloc_wreg[i];
          destMem[tail + tag_t'(i)] <= alloc_dest[3*i +: 3];
          pcMem[tail + tag_t'(i)]   <= alloc_pc[16*i +: 16];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: directed vector table, hand-written multi-cycle
// sequences (reset, full/wrap, flush) and a randomized run against a queue
// model of the buffer.
module tb_rob_retire;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  alloc_count;
  logic [3:0]  alloc_wreg;
  logic [11:0] alloc_dest;
  logic [63:0] alloc_pc;
  logic        alloc_ready;
  logic [23:0] alloc_tag;
  logic [22:0] forwardA, forwardB, forwardC, forwardD;
  logic        flush;
  logic [5:0]  lookup_tag0, lookup_tag1;
  logic        lookup_ready0, lookup_ready1;
  logic [15:0] lookup_value0, lookup_value1;
  logic        wen0, wen1;
  logic [2:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  retire_count;
  logic [15:0] retire_pc0, retire_pc1;
  logic [6:0]  rob_count;

  always #5 clk = ~clk;

  rob_retire #(.DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_count(alloc_count), .alloc_wreg(alloc_wreg),
    .alloc_dest(alloc_dest), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .forwardA(forwardA), .forwardB(forwardB),
    .forwardC(forwardC), .forwardD(forwardD),
    .flush(flush),
    .lookup_tag0(lookup_tag0), .lookup_tag1(lookup_tag1),
    .lookup_ready0(lookup_ready0), .lookup_ready1(lookup_ready1),
    .lookup_value0(lookup_value0), .lookup_value1(lookup_value1),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .retire_count(retire_count),
    .retire_pc0(retire_pc0), .retire_pc1(retire_pc1),
    .rob_count(rob_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] fw(input int tag, input int val);
    return {1'b1, 6'(tag), 16'(val)};
  endfunction

  // Apply one cycle of inputs at the falling edge, then settle after the
  // rising edge so registered outputs can be sampled.
  task automatic drv(input logic [2:0] ac, input logic [3:0] wr, input logic [11:0] de,
                     input logic [63:0] pc, input logic [22:0] fa, input logic [22:0] fb,
                     input logic [22:0] fc, input logic [22:0] fd, input logic fl);
    @(negedge clk);
    alloc_count = ac; alloc_wreg = wr; alloc_dest = de; alloc_pc = pc;
    forwardA = fa; forwardB = fb; forwardC = fc; forwardD = fd; flush = fl;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  ac;
    logic [3:0]  wreg;
    logic [11:0] dest;
    logic [63:0] pc;
    logic [22:0] fa, fb, fc, fd;
    logic [1:0]  expRc;
    logic        expW0;
    logic [2:0]  expA0;
    logic [15:0] expD0;
    logic        expW1;
    logic [2:0]  expA1;
    logic [15:0] expD1;
    logic [6:0]  expCnt;
    logic [5:0]  expTag0;
  } vec_t;

  function automatic vec_t mk(input int ac, input int wreg, input logic [11:0] dest,
                              input logic [63:0] pc, input logic [22:0] fa, input logic [22:0] fb,
                              input logic [22:0] fc, input logic [22:0] fd,
                              input int rc, input int w0, input int a0, input int d0,
                              input int w1, input int a1, input int d1,
                              input int cnt, input int tag0);
    vec_t v;
    v.ac = 3'(ac); v.wreg = 4'(wreg); v.dest = dest; v.pc = pc;
    v.fa = fa; v.fb = fb; v.fc = fc; v.fd = fd;
    v.expRc = 2'(rc); v.expW0 = 1'(w0); v.expA0 = 3'(a0); v.expD0 = 16'(d0);
    v.expW1 = 1'(w1); v.expA1 = 3'(a1); v.expD1 = 16'(d1);
    v.expCnt = 7'(cnt); v.expTag0 = 6'(tag0);
    return v;
  endfunction

  // ---------------- queue reference model ----------------
  typedef struct {
    logic [5:0]  tag;
    logic        rdy;
    logic [15:0] val;
    logic        wreg;
    logic [2:0]  dest;
    logic [15:0] pc;
  } ment_t;

  ment_t mq[$];
  int    mTail;

  function automatic int modelRetires();
    int n;
    n = 0;
    if (mq.size() >= 1 && mq[0].rdy) n = 1;
    if (n == 1 && mq.size() >= 2 && mq[1].rdy) n = 2;
    return n;
  endfunction

  task automatic modelCheck();
    int n;
    int erc;
    logic e0;
    n = mq.size();
    erc = modelRetires();
    chk("rob_count", 64'(rob_count), 64'(n));
    chk("alloc_ready", 64'(alloc_ready), 64'((64 - n) >= 4));
    for (int i = 0; i < 4; i++) begin
      chk("alloc_tag", 64'(alloc_tag[6*i +: 6]), 64'((mTail + i) % 64));
    end
    chk("retire_count", 64'(retire_count), 64'(erc));
    e0 = (erc >= 1) && mq[0].wreg;
    if (erc == 2 && mq[0].wreg && mq[1].wreg && mq[0].dest == mq[1].dest) e0 = 1'b0;
    chk("wen0", 64'(wen0), 64'(e0));
    chk("wen1", 64'(wen1), 64'((erc == 2) && mq[1].wreg));
    if (erc >= 1) begin
      chk("waddr0", 64'(waddr0), 64'(mq[0].dest));
      chk("wdata0", 64'(wdata0), 64'(mq[0].val));
      chk("retire_pc0", 64'(retire_pc0), 64'(mq[0].pc));
    end
    if (erc == 2) begin
      chk("waddr1", 64'(waddr1), 64'(mq[1].dest));
      chk("wdata1", 64'(wdata1), 64'(mq[1].val));
      chk("retire_pc1", 64'(retire_pc1), 64'(mq[1].pc));
    end
  endtask

  // Advance the model across one edge using the inputs currently driven.
  task automatic modelUpdate();
    int nPre;
    int erc;
    logic [22:0] fv[4];
    ment_t e;
    if (flush) begin
      mq.delete();
      mTail = 0;
      return;
    end
    nPre = mq.size();
    erc  = modelRetires();
    fv[0] = forwardA; fv[1] = forwardB; fv[2] = forwardC; fv[3] = forwardD;
    for (int b = 0; b < 4; b++) begin
      if (fv[b][22]) begin
        for (int j = 0; j < mq.size(); j++) begin
          if (mq[j].tag == fv[b][21:16]) begin
            e = mq[j]; e.rdy = 1'b1; e.val = fv[b][15:0]; mq[j] = e;
          end
        end
      end
    end
    for (int j = 0; j < erc; j++) void'(mq.pop_front());
    if (alloc_count >= 1 && alloc_count <= 4 && (64 - nPre) >= 4) begin
      for (int i = 0; i < int'(alloc_count); i++) begin
        e.tag = 6'((mTail + i) % 64); e.rdy = 1'b0; e.val = 16'h0;
        e.wreg = alloc_wreg[i]; e.dest = alloc_dest[3*i +: 3]; e.pc = alloc_pc[16*i +: 16];
        mq.push_back(e);
      end
      mTail = (mTail + int'(alloc_count)) % 64;
    end
  endtask

  // ---------------- test ----------------
  vec_t        tbl[14];
  logic [22:0] Z;
  logic [11:0] DST;
  logic [63:0] PCS;
  logic [23:0] firstTags;

  initial begin
    Z = '0;
    DST = {3'd4, 3'd3, 3'd2, 3'd1};
    PCS = {16'd6, 16'd4, 16'd2, 16'd0};
    firstTags = {6'd3, 6'd2, 6'd1, 6'd0};

    tbl[0]  = mk(4, 'hF, DST, PCS, Z, Z, Z, Z,                             0, 0, 0, 0, 0, 0, 0, 4, 4);
    tbl[1]  = mk(0, 0, 0, 0, fw(0, 'h11), fw(1, 'h22), Z, Z,               2, 1, 1, 'h11, 1, 2, 'h22, 4, 4);
    tbl[2]  = mk(0, 0, 0, 0, Z, Z, Z, Z,                                   0, 0, 0, 0, 0, 0, 0, 2, 4);
    tbl[3]  = mk(0, 0, 0, 0, fw(3, 'h44), Z, Z, Z,                         0, 0, 0, 0, 0, 0, 0, 2, 4);
    tbl[4]  = mk(0, 0, 0, 0, Z, Z, fw(2, 'h33), Z,                         2, 1, 3, 'h33, 1, 4, 'h44, 2, 4);
    tbl[5]  = mk(2, 'h3, {3'd0, 3'd0, 3'd5, 3'd5}, {32'd0, 16'h22, 16'h20}, Z, Z, Z, Z,
                                                                           0, 0, 0, 0, 0, 0, 0, 2, 6);
    tbl[6]  = mk(0, 0, 0, 0, fw(4, 1), fw(5, 2), Z, Z,                     2, 0, 5, 1, 1, 5, 2, 2, 6);
    tbl[7]  = mk(0, 0, 0, 0, Z, Z, Z, Z,                                   0, 0, 0, 0, 0, 0, 0, 0, 6);
    tbl[8]  = mk(1, 'h1, 12'd7, 64'h100, Z, Z, Z, Z,                       0, 0, 0, 0, 0, 0, 0, 1, 7);
    tbl[9]  = mk(0, 0, 0, 0, fw(6, 'hAAAA), Z, Z, fw(6, 'hDDDD),           1, 1, 7, 'hDDDD, 0, 0, 0, 1, 7);
    tbl[10] = mk(0, 0, 0, 0, Z, Z, Z, Z,                                   0, 0, 0, 0, 0, 0, 0, 0, 7);
    tbl[11] = mk(5, 'hF, DST, PCS, fw(6, 'h5555), Z, Z, Z,                 0, 0, 0, 0, 0, 0, 0, 0, 7);
    tbl[12] = mk(1, 0, 12'd2, 64'h0, Z, Z, Z, Z,                           0, 0, 0, 0, 0, 0, 0, 1, 8);
    tbl[13] = mk(0, 0, 0, 0, fw(7, 'h77), Z, Z, Z,                         1, 0, 2, 'h77, 0, 0, 0, 1, 8);

    alloc_count = 0; alloc_wreg = 0; alloc_dest = 0; alloc_pc = 0;
    forwardA = 0; forwardB = 0; forwardC = 0; forwardD = 0; flush = 0;
    lookup_tag0 = 0; lookup_tag1 = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset rob_count", 64'(rob_count), 64'd0);
    chk("reset alloc_ready", 64'(alloc_ready), 64'd1);
    chk("reset alloc_tag", 64'(alloc_tag), 64'(firstTags));
    chk("reset retire_count", 64'(retire_count), 64'd0);
    chk("reset wen0", 64'(wen0), 64'd0);
    chk("reset wen1", 64'(wen1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      drv(tbl[r].ac, tbl[r].wreg, tbl[r].dest, tbl[r].pc,
          tbl[r].fa, tbl[r].fb, tbl[r].fc, tbl[r].fd, 1'b0);
      chk($sformatf("vec%0d retire_count", r), 64'(retire_count), 64'(tbl[r].expRc));
      chk($sformatf("vec%0d wen0", r), 64'(wen0), 64'(tbl[r].expW0));
      chk($sformatf("vec%0d wen1", r), 64'(wen1), 64'(tbl[r].expW1));
      chk($sformatf("vec%0d rob_count", r), 64'(rob_count), 64'(tbl[r].expCnt));
      chk($sformatf("vec%0d alloc_tag0", r), 64'(alloc_tag[5:0]), 64'(tbl[r].expTag0));
      if (tbl[r].expRc >= 1) begin
        chk($sformatf("vec%0d waddr0", r), 64'(waddr0), 64'(tbl[r].expA0));
        chk($sformatf("vec%0d wdata0", r), 64'(wdata0), 64'(tbl[r].expD0));
      end
      if (tbl[r].expRc == 2) begin
        chk($sformatf("vec%0d waddr1", r), 64'(waddr1), 64'(tbl[r].expA1));
        chk($sformatf("vec%0d wdata1", r), 64'(wdata1), 64'(tbl[r].expD1));
      end
    end

    // ---- reset in the middle of a run ----
    drv(0, 0, 0, 0, Z, Z, Z, Z, 0);
    drv(4, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    drv(4, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    drv(2, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    chk("midrun count", 64'(rob_count), 64'd10);
    drv(0, 0, 0, 0, fw(8, 'h1234), Z, Z, Z, 0);
    chk("midrun retire_count", 64'(retire_count), 64'd1);
    @(negedge clk);
    forwardA = Z;
    rst_n = 1'b0;
    #1;
    chk("midrun reset rob_count", 64'(rob_count), 64'd0);
    chk("midrun reset wen0", 64'(wen0), 64'd0);
    chk("midrun reset wen1", 64'(wen1), 64'd0);
    chk("midrun reset retire_count", 64'(retire_count), 64'd0);
    chk("midrun reset alloc_tag0", 64'(alloc_tag[5:0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- fill to 64, then drain a little and wrap ----
    for (int i = 0; i < 15; i++) drv(4, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    chk("full60 count", 64'(rob_count), 64'd60);
    chk("full60 alloc_ready", 64'(alloc_ready), 64'd1);
    drv(4, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    chk("full64 count", 64'(rob_count), 64'd64);
    chk("full64 alloc_ready", 64'(alloc_ready), 64'd0);
    drv(1, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    chk("full ignored alloc", 64'(rob_count), 64'd64);
    drv(0, 0, 0, 0, fw(0, 'hA0), fw(1, 'hB1), fw(2, 'hC2), Z, 0);
    chk("full retire_count", 64'(retire_count), 64'd2);
    chk("full waddr0", 64'(waddr0), 64'd1);
    chk("full wdata0", 64'(wdata0), 64'hA0);
    chk("full waddr1", 64'(waddr1), 64'd2);
    chk("full wdata1", 64'(wdata1), 64'hB1);
    drv(0, 0, 0, 0, Z, Z, Z, Z, 0);
    chk("drain62 count", 64'(rob_count), 64'd62);
    chk("drain62 alloc_ready", 64'(alloc_ready), 64'd0);
    chk("drain62 wdata0", 64'(wdata0), 64'hC2);
    drv(0, 0, 0, 0, Z, Z, Z, Z, 0);
    chk("drain61 count", 64'(rob_count), 64'd61);
    chk("drain61 alloc_ready", 64'(alloc_ready), 64'd0);
    drv(1, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    chk("count61 alloc ignored", 64'(rob_count), 64'd61);
    drv(0, 0, 0, 0, Z, Z, Z, fw(3, 'hD3), 0);
    chk("drain tag3 retire_count", 64'(retire_count), 64'd1);
    drv(0, 0, 0, 0, Z, Z, Z, Z, 0);
    chk("drain60 count", 64'(rob_count), 64'd60);
    chk("drain60 alloc_ready", 64'(alloc_ready), 64'd1);
    chk("wrap alloc_tag", 64'(alloc_tag), 64'(firstTags));
    drv(4, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    chk("wrap count", 64'(rob_count), 64'd64);
    chk("wrap tail", 64'(alloc_tag[5:0]), 64'd4);

    // ---- flush ----
    drv(4, 'hF, DST, PCS, fw(4, 1), Z, Z, Z, 1);
    chk("flush count", 64'(rob_count), 64'd0);
    chk("flush tail", 64'(alloc_tag[5:0]), 64'd0);
    drv(4, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    drv(4, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    chk("flush8 count", 64'(rob_count), 64'd8);
    drv(0, 0, 0, 0, fw(0, 'h100), fw(1, 'h200), fw(2, 'h300), Z, 0);
    @(negedge clk);
    forwardA = Z; forwardB = Z; forwardC = Z; flush = 1'b1;
    #1;
    chk("preflush retire_count", 64'(retire_count), 64'd2);
    chk("preflush wen0", 64'(wen0), 64'd1);
    chk("preflush wdata0", 64'(wdata0), 64'h100);
    chk("preflush wen1", 64'(wen1), 64'd1);
    chk("preflush wdata1", 64'(wdata1), 64'h200);
    chk("preflush retire_pc1", 64'(retire_pc1), 64'd2);
    @(posedge clk);
    #1;
    chk("postflush count", 64'(rob_count), 64'd0);
    chk("postflush retire_count", 64'(retire_count), 64'd0);
    lookup_tag0 = 6'd3;
    lookup_tag1 = 6'd0;
    drv(0, 0, 0, 0, fw(3, 'h999), fw(0, 'h999), Z, Z, 0);
    chk("stale fwd lookup_ready0", 64'(lookup_ready0), 64'd0);
    chk("stale fwd lookup_ready1", 64'(lookup_ready1), 64'd0);
    chk("stale fwd count", 64'(rob_count), 64'd0);
    drv(1, 'hF, DST, PCS, Z, Z, Z, Z, 0);
    chk("postflush alloc count", 64'(rob_count), 64'd1);
    chk("postflush alloc retire", 64'(retire_count), 64'd0);

    // ---- randomized run against the queue model ----
    @(negedge clk);
    alloc_count = 0; forwardA = Z; forwardB = Z; forwardC = Z; forwardD = Z; flush = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    mTail = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [22:0] fv[4];
      int li;
      @(negedge clk);
      modelCheck();
      alloc_count = 3'($urandom_range(0, 5));
      alloc_wreg  = 4'($urandom);
      alloc_dest  = 12'($urandom);
      alloc_pc    = {$urandom, $urandom};
      for (int b = 0; b < 4; b++) begin
        logic [5:0] t;
        if ($urandom_range(0, 2) != 0 && mq.size() > 0) t = mq[$urandom_range(0, mq.size() - 1)].tag;
        else t = 6'($urandom_range(0, 63));
        fv[b] = {1'($urandom_range(0, 3) != 0), t, 16'($urandom)};
      end
      forwardA = fv[0]; forwardB = fv[1]; forwardC = fv[2]; forwardD = fv[3];
      flush = ($urandom_range(0, 99) == 0);
      li = (mq.size() > 0) ? int'($urandom_range(0, mq.size() - 1)) : 0;
      if (mq.size() > 0) lookup_tag0 = mq[li].tag;
      #1;
      if (mq.size() > 0) begin
        chk("lookup_ready0", 64'(lookup_ready0), 64'(mq[li].rdy));
        if (mq[li].rdy) chk("lookup_value0", 64'(lookup_value0), 64'(mq[li].val));
      end
      modelUpdate();
    end
    @(negedge clk);
    modelCheck();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
